// File: rtl/kgp_alu_pkg.sv
// Shared ALU definitions for the KGP-RISC execute stage.
// Holds the datapath width and the sequential divider state encoding.
package kgp_alu_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } div_state_t;

    localparam logic [WIDTH-1:0] DIV_ZERO_QUO = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, try to subtract.
// Purely combinational so it can be exercised on its own.
module div_step
    import kgp_alu_pkg::*;
(
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor_mag,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0]   shifted_high;
    logic [WIDTH+1:0] trial;
    logic             fits;

    // One extra bit beyond WIDTH+1 so the borrow is visible as a sign bit.
    assign shifted_high = {rem, quo[WIDTH-1]};
    assign trial        = {1'b0, shifted_high} - {2'b00, divisor_mag};
    assign fits         = ~trial[WIDTH+1];

    assign rem_next = fits ? trial[WIDTH-1:0] : shifted_high[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/shift_divider.sv
// Sequential restoring divider with start/done handshake.
// Operates on magnitudes and restores the signs in a final fix-up cycle.
module shift_divider
    import kgp_alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    div_state_t       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] dvs_mag;
    logic             q_neg;
    logic             r_neg;
    logic             dz_pend;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             b_zero;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    assign a_neg  = is_signed & dividend[WIDTH-1];
    assign b_neg  = is_signed & divisor[WIDTH-1];
    assign a_mag  = a_neg ? -dividend : dividend;
    assign b_mag  = b_neg ? -divisor : divisor;
    assign b_zero = (divisor == '0);

    div_step u_step (
        .rem         (rem_reg),
        .quo         (quo_reg),
        .divisor_mag (dvs_mag),
        .rem_next    (rem_next),
        .quo_next    (quo_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            dvs_mag     <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dz_pend     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    // The done cycle is spent in IDLE; a start there is dropped.
                    if (start && !done) begin
                        busy    <= 1'b1;
                        cnt     <= '0;
                        q_neg   <= a_neg ^ b_neg;
                        r_neg   <= a_neg;
                        dvs_mag <= b_mag;
                        rem_reg <= '0;
                        dz_pend <= b_zero;
                        quo_reg <= b_zero ? dividend : a_mag;
                        state   <= b_zero ? DONE : RUN;
                    end
                end
                RUN: begin
                    rem_reg <= rem_next;
                    quo_reg <= quo_next;
                    cnt     <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    quotient    <= q_neg ? -quo_reg : quo_reg;
                    remainder   <= r_neg ? -rem_reg : rem_reg;
                    div_by_zero <= 1'b0;
                    state       <= DONE;
                end
                DONE: begin
                    if (dz_pend) begin
                        quotient    <= DIV_ZERO_QUO;
                        remainder   <= quo_reg;
                        div_by_zero <= 1'b1;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
